// File: rtl/fp32_mult_arbiter.sv
// Round-robin front end for a shared FP32 multiplier.
// Grants one requester per cycle, registers its operands into the multiplier,
// carries the requester ID down a tag pipe matched to the multiplier latency,
// and returns product/flags to the owner on a one-hot response strobe.
module fp32_mult_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MULT_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*32-1:0]   req_a_i,
  input  logic [NREQ*32-1:0]   req_b_i,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic [31:0]          mult_a_o,
  output logic [31:0]          mult_b_o,
  input  logic [31:0]          mult_result_i,
  input  logic [4:0]           mult_flags_i,
  output logic [NREQ-1:0]      resp_valid_o,
  output logic [31:0]          resp_result_o,
  output logic [4:0]           resp_flags_o,
  output logic                 busy_o,
  output logic [15:0]          issue_count_o
);

  localparam int unsigned IDW    = $clog2(NREQ);
  localparam int unsigned STAGES = MULT_LAT + 1;
  localparam int unsigned DW     = 32;
  localparam int unsigned FW     = 5;
  localparam int unsigned CW     = 16;

  logic [IDW-1:0]             ptr_q, ptr_d;
  logic [DW-1:0]              mult_a_q, mult_a_d;
  logic [DW-1:0]              mult_b_q, mult_b_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [STAGES-1:0]          tag_vld_q, tag_vld_d;
  logic [STAGES-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NREQ-1:0]            resp_valid_q, resp_valid_d;
  logic [DW-1:0]              resp_result_q, resp_result_d;
  logic [FW-1:0]              resp_flags_q, resp_flags_d;

  logic                       grant_found;
  logic                       grant_en;
  logic [IDW-1:0]             grant_id;
  int unsigned                idx;

  // Round-robin search starting at ptr; grant is suppressed by hold, flush or reset.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid_i[IDW'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
    grant_en    = grant_found && !hold_i && !flush_i && !rst;
    req_ready_o = grant_en ? (NREQ'(1) << grant_id) : '0;
  end

  // Next-state: operand capture, pointer advance, tag shift and response capture.
  always_comb begin
    ptr_d         = ptr_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    cnt_d         = cnt_q;
    tag_vld_d     = '0;
    tag_id_d      = tag_id_q;
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;

    if (grant_en) begin
      mult_a_d = req_a_i[32'(grant_id)*DW +: DW];
      mult_b_d = req_b_i[32'(grant_id)*DW +: DW];
      ptr_d    = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
      cnt_d    = cnt_q + CW'(1);
    end

    // Flush leaves the tag pipe and response strobe all-invalid.
    if (!flush_i) begin
      tag_vld_d[0] = grant_en;
      tag_id_d[0]  = grant_id;
      for (int unsigned s = 1; s < STAGES; s++) begin
        tag_vld_d[s] = tag_vld_q[s-1];
        tag_id_d[s]  = tag_id_q[s-1];
      end
      if (tag_vld_q[STAGES-1]) begin
        resp_valid_d  = NREQ'(1) << tag_id_q[STAGES-1];
        resp_result_d = mult_result_i;
        resp_flags_d  = mult_flags_i;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      cnt_q         <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
    end else begin
      ptr_q         <= ptr_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      cnt_q         <= cnt_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  assign mult_a_o      = mult_a_q;
  assign mult_b_o      = mult_b_q;
  assign issue_count_o = cnt_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = resp_result_q;
  assign resp_flags_o  = resp_flags_q;
  assign busy_o        = (|tag_vld_q) | (|resp_valid_q);

endmodule
